mem_port_arbiter: RTL and testbench

Arbitrates the single shared memory bus port between the instruction-fetch stage and the MEM-stage data path of the 5-stage RISC-V pipeline. It holds one outstanding bus transaction at a time, sequences each transaction through request, acknowledge and response, and routes the response back to its owner. Data requests have priority over fetch, and a bounded starvation counter guarantees forward progress for fetch.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch and the MEM-stage data path.
// Latency: gnt in the request cycle, bus_req the next cycle, done one cycle after bus_rvalid.
// Backpressure: one transaction in flight; new requests wait in IDLE until the bus responds.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic                dm_gnt,
  output logic                dm_done,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_ack,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] starve_cnt;
  logic       owner_dm;   // 1 when the in-flight transaction belongs to the data path
  logic       pick_if;    // fetch wins the current arbitration
  logic       finish;     // bus response completes the in-flight transaction this cycle

  // Data path has priority; fetch wins only when alone or after STARVE_MAX contested data wins.
  assign pick_if = if_req && (!dm_req || (starve_cnt == STARVE_LIM));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state, combinational grants and transaction-finish detection.
  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          if_gnt    = pick_if;
          dm_gnt    = !pick_if;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus_ack) begin
          if (bus_rvalid) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winner's payload at grant and hold the bus request until it is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_dm  <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      if (if_gnt || dm_gnt) begin
        owner_dm  <= dm_gnt;
        bus_req   <= 1'b1;
        bus_we    <= dm_gnt && dm_we;
        bus_addr  <= dm_gnt ? dm_addr : if_addr;
        bus_wdata <= dm_gnt ? dm_wdata : '0;
        bus_wstrb <= dm_gnt ? dm_wstrb : '0;
      end else if (state == ISSUE && bus_ack) begin
        bus_req <= 1'b0;
      end
    end
  end

  // Route the bus response to the owner; the other requester's rdata keeps its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_done  <= 1'b0;
      dm_done  <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_done <= finish && !owner_dm;
      dm_done <= finish && owner_dm;
      if (finish && !owner_dm) if_rdata <= bus_rdata;
      if (finish && owner_dm)  dm_rdata <= bus_we ? '0 : bus_rdata;
    end
  end

  // Count contested data wins so fetch is forced through after STARVE_MAX of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if (dm_gnt && if_req && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model of arbitration and bus sequencing.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 64;
  localparam int STARVE_MAX = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                if_req;
  logic [ADDR_W-1:0]   if_addr;
  logic                if_gnt, if_done;
  logic [DATA_W-1:0]   if_rdata;
  logic                dm_req, dm_we;
  logic [ADDR_W-1:0]   dm_addr;
  logic [DATA_W-1:0]   dm_wdata;
  logic [DATA_W/8-1:0] dm_wstrb;
  logic                dm_gnt, dm_done;
  logic [DATA_W-1:0]   dm_rdata;
  logic                bus_req, bus_we;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   bus_wdata;
  logic [DATA_W/8-1:0] bus_wstrb;
  logic                bus_ack, bus_rvalid;
  logic [DATA_W-1:0]   bus_rdata;
  logic                busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    bus_ack = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
  endtask

  task automatic do_reset();
    tick(); clear_inputs(); reset = 1'b1;
    tick(); reset = 1'b0;
  endtask

  function automatic logic any_output();
    return |{if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
             bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, busy};
  endfunction

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (any_output() !== 1'b0) begin n_fail++; $display("FAIL reset_outputs: some output nonzero, got 1 expected 0"); end
    tick(); reset = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_load();
    tick(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h1000;
    @(negedge clk);  // N
    n_checks++; if ({dm_gnt, if_gnt, bus_req} !== 3'b100) begin n_fail++; $display("FAIL load_gnt: {dm_gnt,if_gnt,bus_req}=%b expected 100", {dm_gnt, if_gnt, bus_req}); end
    tick(); dm_req = 1'b0; bus_ack = 1'b1;
    @(negedge clk);  // N+1
    n_checks++; if ({bus_req, bus_we, busy, dm_gnt} !== 4'b1010) begin n_fail++; $display("FAIL load_issue: {bus_req,bus_we,busy,dm_gnt}=%b expected 1010", {bus_req, bus_we, busy, dm_gnt}); end
    n_checks++; if (bus_addr !== 64'h1000) begin n_fail++; $display("FAIL load_addr: got %h expected 1000", bus_addr); end
    tick(); bus_ack = 1'b0;
    @(negedge clk);  // N+2
    n_checks++; if ({bus_req, busy, dm_done} !== 3'b010) begin n_fail++; $display("FAIL load_wait: {bus_req,busy,dm_done}=%b expected 010", {bus_req, busy, dm_done}); end
    tick(); bus_rvalid = 1'b1; bus_rdata = 64'hDEADBEEF;
    @(negedge clk);  // N+3
    n_checks++; if (dm_done !== 1'b0) begin n_fail++; $display("FAIL load_early_done: got %b expected 0", dm_done); end
    tick(); bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);  // N+4
    n_checks++; if ({dm_done, if_done, if_gnt, busy} !== 4'b1000) begin n_fail++; $display("FAIL load_done: {dm_done,if_done,if_gnt,busy}=%b expected 1000", {dm_done, if_done, if_gnt, busy}); end
    n_checks++; if (dm_rdata !== 64'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata: got %h expected deadbeef", dm_rdata); end
    n_checks++; if (if_rdata !== 64'h0) begin n_fail++; $display("FAIL load_if_rdata: got %h expected 0", if_rdata); end
  endtask

  task automatic test_store_zero_wait();
    tick(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h2000; dm_wdata = 64'h55; dm_wstrb = 8'h0F;
    @(negedge clk);
    n_checks++; if (dm_gnt !== 1'b1) begin n_fail++; $display("FAIL store_gnt: got %b expected 1", dm_gnt); end
    tick(); clear_inputs(); bus_ack = 1'b1; bus_rvalid = 1'b1; bus_rdata = 64'h1234_5678;
    @(negedge clk);
    n_checks++; if ({bus_req, bus_we, bus_wstrb} !== 10'b11_0000_1111) begin n_fail++; $display("FAIL store_issue: {bus_req,bus_we,bus_wstrb}=%b expected 11_00001111", {bus_req, bus_we, bus_wstrb}); end
    n_checks++; if (bus_wdata !== 64'h55) begin n_fail++; $display("FAIL store_wdata: got %h expected 55", bus_wdata); end
    tick(); bus_ack = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);
    n_checks++; if ({dm_done, busy} !== 2'b10) begin n_fail++; $display("FAIL store_done: {dm_done,busy}=%b expected 10", {dm_done, busy}); end
    n_checks++; if (dm_rdata !== 64'h0) begin n_fail++; $display("FAIL store_rdata: got %h expected 0", dm_rdata); end
  endtask

  task automatic test_contention();
    bit got_if[10];
    int gcyc[10];
    int ng = 0;
    int cnt = 0;
    bit exp_if;
    do_reset();
    tick(); if_req = 1'b1; if_addr = 64'h40; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h80;
    for (int cyc = 0; cyc < 100 && ng < 10; cyc++) begin
      if (cyc > 0) begin tick(); bus_ack = bus_req; bus_rvalid = bus_req; bus_rdata = 64'(cyc); end
      @(negedge clk);
      n_checks++; if ((if_gnt & dm_gnt) !== 1'b0) begin n_fail++; $display("FAIL cont_dual_gnt: both grants at cycle %0d", cyc); end
      if (if_gnt || dm_gnt) begin got_if[ng] = if_gnt; gcyc[ng] = cyc; ng++; end
    end
    n_checks++; if (ng != 10) begin n_fail++; $display("FAIL cont_grant_count: got %0d expected 10", ng); end
    // Fetch must win exactly after STARVE_MAX consecutive contested data wins.
    for (int k = 0; k < ng; k++) begin
      exp_if = (cnt == STARVE_MAX);
      cnt = exp_if ? 0 : cnt + 1;
      n_checks++; if (got_if[k] !== exp_if) begin n_fail++; $display("FAIL cont_order[%0d]: if_won=%b expected %b", k, got_if[k], exp_if); end
      n_checks++; if (gcyc[k] != 2 * k) begin n_fail++; $display("FAIL cont_rate[%0d]: grant cycle %0d expected %0d", k, gcyc[k], 2 * k); end
    end
    repeat (3) begin tick(); if_req = 1'b0; dm_req = 1'b0; bus_ack = bus_req; bus_rvalid = bus_req; end
    tick(); clear_inputs();
  endtask

  task automatic test_stalled_ack();
    tick(); if_req = 1'b1; if_addr = 64'hABC0;
    @(negedge clk);
    n_checks++; if ({if_gnt, dm_gnt} !== 2'b10) begin n_fail++; $display("FAIL stall_gnt: {if_gnt,dm_gnt}=%b expected 10", {if_gnt, dm_gnt}); end
    tick(); if_req = 1'b0; if_addr = 64'hFFFF; dm_req = 1'b1; dm_addr = 64'h9999;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if ({bus_req, bus_we, bus_wstrb, busy, if_gnt, dm_gnt} !== 13'b10_0000_0000_100) begin n_fail++; $display("FAIL stall_ctrl[%0d]: {req,we,wstrb,busy,ig,dg}=%b expected 1000000000100", i, {bus_req, bus_we, bus_wstrb, busy, if_gnt, dm_gnt}); end
      n_checks++; if (bus_addr !== 64'hABC0) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h expected abc0", i, bus_addr); end
      if (i < 4) tick();
    end
    tick(); dm_req = 1'b0; bus_ack = 1'b1; bus_rvalid = 1'b1; bus_rdata = 64'hC0FFEE;
    @(negedge clk);
    n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL stall_ack_cycle: bus_req=%b expected 1", bus_req); end
    tick(); clear_inputs();
    @(negedge clk);
    n_checks++; if ({if_done, dm_done} !== 2'b10) begin n_fail++; $display("FAIL stall_done: {if_done,dm_done}=%b expected 10", {if_done, dm_done}); end
    n_checks++; if (if_rdata !== 64'hC0FFEE) begin n_fail++; $display("FAIL stall_rdata: got %h expected c0ffee", if_rdata); end
  endtask

  task automatic test_reset_in_wait();
    tick(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h3000;
    tick(); dm_req = 1'b0; bus_ack = 1'b1;
    tick(); bus_ack = 1'b0;
    @(negedge clk);
    n_checks++; if ({busy, bus_req} !== 2'b10) begin n_fail++; $display("FAIL rstw_in_wait: {busy,bus_req}=%b expected 10", {busy, bus_req}); end
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'hBAD;
    @(negedge clk);
    n_checks++; if (any_output() !== 1'b0) begin n_fail++; $display("FAIL rstw_outputs: some output nonzero, got 1 expected 0"); end
    tick(); bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);
    n_checks++; if ({dm_done, if_done, busy} !== 3'b000) begin n_fail++; $display("FAIL rstw_late_rvalid: {dm_done,if_done,busy}=%b expected 000", {dm_done, if_done, busy}); end
    n_checks++; if (dm_rdata !== 64'h0) begin n_fail++; $display("FAIL rstw_rdata: got %h expected 0", dm_rdata); end
    tick(); if_req = 1'b1; if_addr = 64'h2000;
    @(negedge clk);
    n_checks++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL rstw_regrant: if_gnt=%b expected 1", if_gnt); end
    tick(); if_req = 1'b0; bus_ack = 1'b1; bus_rvalid = 1'b1; bus_rdata = 64'h77;
    @(negedge clk);
    n_checks++; if (bus_addr !== 64'h2000) begin n_fail++; $display("FAIL rstw_addr: got %h expected 2000", bus_addr); end
    tick(); clear_inputs();
    @(negedge clk);
    n_checks++; if ({if_done, if_rdata} !== {1'b1, 64'h77}) begin n_fail++; $display("FAIL rstw_done: if_done=%b if_rdata=%h expected 1/77", if_done, if_rdata); end
  endtask

  task automatic test_spurious();
    tick(); bus_ack = 1'b1; bus_rvalid = 1'b1; bus_rdata = 64'h5A5A;
    @(negedge clk);
    n_checks++; if ({busy, bus_req, if_gnt, dm_gnt} !== 4'b0000) begin n_fail++; $display("FAIL spur_idle: {busy,bus_req,ig,dg}=%b expected 0000", {busy, bus_req, if_gnt, dm_gnt}); end
    tick(); clear_inputs();
    @(negedge clk);
    n_checks++; if ({if_done, dm_done, busy, bus_req} !== 4'b0000) begin n_fail++; $display("FAIL spur_done: {if_done,dm_done,busy,bus_req}=%b expected 0000", {if_done, dm_done, busy, bus_req}); end
    n_checks++; if (if_rdata !== 64'h77) begin n_fail++; $display("FAIL spur_rdata: got %h expected 77", if_rdata); end
  endtask

  // Randomized traffic against a transaction-level model.
  task automatic test_random();
    bit if_pend = 0, dm_pend = 0;
    bit s_wait = 0;
    int s_delay = 0;
    bit m_active = 0, m_acked = 0;
    int starve = 0;
    bit t_dm = 0, t_we = 0;
    logic [ADDR_W-1:0] t_addr = '0;
    logic [DATA_W-1:0] t_wdata = '0;
    logic [DATA_W/8-1:0] t_wstrb = '0;
    bit e_if_done = 0, e_dm_done = 0;
    logic [DATA_W-1:0] e_if_rdata = '0, e_dm_rdata = '0;
    bit e_ig, e_dg, pick_if;
    int forced = 0;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (!if_pend && $urandom_range(2) == 0) begin if_pend = 1; if_addr = {$urandom, $urandom}; end
      if (!dm_pend && $urandom_range(1) == 0) begin
        dm_pend = 1; dm_we = 1'($urandom_range(1)); dm_addr = {$urandom, $urandom};
        dm_wdata = {$urandom, $urandom}; dm_wstrb = 8'($urandom);
      end
      if_req = if_pend; dm_req = dm_pend;
      bus_ack = 1'b0; bus_rvalid = 1'b0; bus_rdata = {$urandom, $urandom};
      if (s_wait) begin
        if (s_delay == 0) begin bus_rvalid = 1'b1; s_wait = 0; end
        else s_delay--;
      end else if (bus_req) begin
        if ($urandom_range(2) == 0) begin
          bus_ack = 1'b1;
          if ($urandom_range(1) == 1) bus_rvalid = 1'b1;
          else begin s_wait = 1; s_delay = $urandom_range(3); end
        end
      end else if ($urandom_range(9) == 0) begin
        bus_ack = 1'b1; bus_rvalid = 1'b1;
      end
      @(negedge clk);
      pick_if = if_pend && (!dm_pend || starve == STARVE_MAX);
      e_ig = !m_active && (if_pend || dm_pend) && pick_if;
      e_dg = !m_active && (if_pend || dm_pend) && !pick_if;
      n_checks++; if ({if_gnt, dm_gnt} !== {e_ig, e_dg}) begin n_fail++; $display("FAIL rnd_gnt c%0d: {ig,dg}=%b expected %b", c, {if_gnt, dm_gnt}, {e_ig, e_dg}); end
      n_checks++; if ({busy, bus_req} !== {m_active, m_active && !m_acked}) begin n_fail++; $display("FAIL rnd_busreq c%0d: {busy,bus_req}=%b expected %b", c, {busy, bus_req}, {m_active, m_active && !m_acked}); end
      if (m_active && !m_acked) begin
        n_checks++; if ({bus_we, bus_addr, bus_wstrb} !== {t_we, t_addr, t_wstrb}) begin n_fail++; $display("FAIL rnd_payload c%0d: we=%b addr=%h strb=%h expected %b/%h/%h", c, bus_we, bus_addr, bus_wstrb, t_we, t_addr, t_wstrb); end
        if (t_dm) begin
          n_checks++; if (bus_wdata !== t_wdata) begin n_fail++; $display("FAIL rnd_wdata c%0d: got %h expected %h", c, bus_wdata, t_wdata); end
        end
      end
      n_checks++; if ({if_done, dm_done} !== {e_if_done, e_dm_done}) begin n_fail++; $display("FAIL rnd_done c%0d: {if_done,dm_done}=%b expected %b", c, {if_done, dm_done}, {e_if_done, e_dm_done}); end
      n_checks++; if ({if_rdata, dm_rdata} !== {e_if_rdata, e_dm_rdata}) begin n_fail++; $display("FAIL rnd_rdata c%0d: if=%h dm=%h expected %h/%h", c, if_rdata, dm_rdata, e_if_rdata, e_dm_rdata); end
      e_if_done = 0; e_dm_done = 0;
      if (m_active) begin
        if ((!m_acked && bus_ack && bus_rvalid) || (m_acked && bus_rvalid)) begin
          m_active = 0;
          if (t_dm) begin e_dm_done = 1; e_dm_rdata = t_we ? '0 : bus_rdata; end
          else begin e_if_done = 1; e_if_rdata = bus_rdata; end
        end else if (!m_acked && bus_ack) begin
          m_acked = 1;
        end
      end else if (e_ig || e_dg) begin
        m_active = 1; m_acked = 0; t_dm = e_dg;
        t_we = e_dg && dm_we; t_addr = e_dg ? dm_addr : if_addr;
        t_wdata = dm_wdata; t_wstrb = e_dg ? dm_wstrb : '0;
        if (e_ig && dm_pend) forced++;
        if (e_ig) starve = 0;
        else if (if_pend) starve++;
        if (e_ig) if_pend = 0; else dm_pend = 0;
      end
    end
    n_checks++; if (forced == 0) begin n_fail++; $display("FAIL rnd_forced_if: forced fetch wins %0d expected >0", forced); end
    tick(); clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store_zero_wait();
    test_contention();
    test_stalled_ack();
    test_reset_in_wait();
    test_spurious();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
